// File: rtl/ecap5_dwbspi_pkg.sv
// Shared register map, bit positions and sequencer state type for the
// ecap5_dwbspi Wishbone SPI sequencer.
package ecap5_dwbspi_pkg;

  localparam logic [1:0] SPI_SR   = 2'd0;
  localparam logic [1:0] SPI_CR   = 2'd1;
  localparam logic [1:0] SPI_RXDR = 2'd2;
  localparam logic [1:0] SPI_TXDR = 2'd3;

  localparam int SR_TXE       = 0;
  localparam int CR_CS        = 0;
  localparam int CR_PRESC_LSB = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CSEL,
    S_WAIT_TX,
    S_WR_TX,
    S_POLL,
    S_RD_RX,
    S_PUSH_RX,
    S_CDESEL
  } seq_state_t;

  // Registers sit on consecutive 32-bit words above the block base.
  function automatic logic [31:0] regAddr(input logic [31:0] base, input logic [1:0] idx);
    return base + {28'd0, idx, 2'b00};
  endfunction

  function automatic logic [31:0] crValue(input logic [15:0] prescaler, input logic cs);
    logic [31:0] value;
    value                        = '0;
    value[CR_PRESC_LSB +: 16]    = prescaler;
    value[CR_CS]                 = cs;
    return value;
  endfunction

endpackage

// File: rtl/ecap5_dwbspi_seq_wbm.sv
// Single-access pipelined Wishbone master: one request in flight, done_o
// pulses in the cycle the access is acknowledged.
module ecap5_dwbspi_seq_wbm (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        done_o,
  output logic        busy_o,
  output logic [31:0] rdata_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  output logic        wb_we_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_stb_o,
  input  logic        wb_ack_i,
  output logic        wb_cyc_o,
  input  logic        wb_stall_i
);

  logic        cyc_q;
  logic        stb_q;
  logic        we_q;
  logic [31:0] adr_q;
  logic [31:0] dat_q;
  logic        ackTaken;

  // An ack only counts once the strobe has been accepted (or is accepted now).
  assign ackTaken = cyc_q && wb_ack_i && (!stb_q || !wb_stall_i);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cyc_q <= 1'b0;
      stb_q <= 1'b0;
      we_q  <= 1'b0;
      adr_q <= '0;
      dat_q <= '0;
    end else if (!cyc_q) begin
      if (req_i) begin
        cyc_q <= 1'b1;
        stb_q <= 1'b1;
        we_q  <= we_i;
        adr_q <= addr_i;
        dat_q <= we_i ? wdata_i : '0;
      end
    end else if (ackTaken) begin
      cyc_q <= 1'b0;
      stb_q <= 1'b0;
      we_q  <= 1'b0;
      adr_q <= '0;
      dat_q <= '0;
    end else if (stb_q && !wb_stall_i) begin
      stb_q <= 1'b0;
    end
  end

  assign done_o   = ackTaken;
  assign busy_o   = cyc_q;
  assign rdata_o  = wb_dat_i;
  assign wb_cyc_o = cyc_q;
  assign wb_stb_o = stb_q;
  assign wb_we_o  = we_q;
  assign wb_adr_o = adr_q;
  assign wb_dat_o = dat_q;
  assign wb_sel_o = 4'hF;

endmodule

// File: rtl/ecap5_dwbspi_seq.sv
// Runs multi-byte SPI transfers through the ecap5_dwbspi register block:
// chip select, per-byte TXDR/SR/RXDR exchange, chip deselect.
module ecap5_dwbspi_seq
  import ecap5_dwbspi_pkg::*;
#(
  parameter logic [31:0] SPI_BASE  = 32'h0000_0000,
  parameter logic [15:0] PRESCALER = 16'd4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [7:0]  cmd_len_i,
  input  logic        tx_valid_i,
  output logic        tx_ready_o,
  input  logic [7:0]  tx_data_i,
  output logic        rx_valid_o,
  input  logic        rx_ready_i,
  output logic [7:0]  rx_data_o,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  output logic        wb_we_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_stb_o,
  input  logic        wb_ack_i,
  output logic        wb_cyc_o,
  input  logic        wb_stall_i
);

  seq_state_t  state_q;
  logic [8:0]  remaining_q;
  logic [7:0]  txByte_q;
  logic [7:0]  rxByte_q;
  logic        cmdReady_q;
  logic        txReady_q;
  logic        rxValid_q;
  logic        busy_q;

  logic        wbReq;
  logic        wbWe;
  logic [31:0] wbAddr;
  logic [31:0] wbWdata;
  logic        wbDone;
  logic        wbBusy;
  logic [31:0] wbRdata;
  logic        unusedRdata;

  // A new access is requested as soon as the master is free in a bus state;
  // POLL therefore reissues the SR read on the cycle after a not-ready ack.
  always_comb begin
    wbReq   = 1'b0;
    wbWe    = 1'b0;
    wbAddr  = '0;
    wbWdata = '0;
    unique case (state_q)
      S_CSEL: begin
        wbReq   = !wbBusy;
        wbWe    = 1'b1;
        wbAddr  = regAddr(SPI_BASE, SPI_CR);
        wbWdata = crValue(PRESCALER, 1'b1);
      end
      S_WR_TX: begin
        wbReq   = !wbBusy;
        wbWe    = 1'b1;
        wbAddr  = regAddr(SPI_BASE, SPI_TXDR);
        wbWdata = {24'd0, txByte_q};
      end
      S_POLL: begin
        wbReq  = !wbBusy;
        wbAddr = regAddr(SPI_BASE, SPI_SR);
      end
      S_RD_RX: begin
        wbReq  = !wbBusy;
        wbAddr = regAddr(SPI_BASE, SPI_RXDR);
      end
      S_CDESEL: begin
        wbReq   = !wbBusy;
        wbWe    = 1'b1;
        wbAddr  = regAddr(SPI_BASE, SPI_CR);
        wbWdata = crValue(PRESCALER, 1'b0);
      end
      default: ;
    endcase
  end

  // Handshake outputs are registered and updated together with the state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      remaining_q <= '0;
      txByte_q    <= '0;
      rxByte_q    <= '0;
      cmdReady_q  <= 1'b0;
      txReady_q   <= 1'b0;
      rxValid_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (cmd_valid_i && cmdReady_q) begin
            remaining_q <= (cmd_len_i == 8'd0) ? 9'd256 : {1'b0, cmd_len_i};
            state_q     <= S_CSEL;
            cmdReady_q  <= 1'b0;
            busy_q      <= 1'b1;
          end else begin
            cmdReady_q  <= 1'b1;
          end
        end
        S_CSEL: begin
          if (wbDone) begin
            state_q   <= S_WAIT_TX;
            txReady_q <= 1'b1;
          end
        end
        S_WAIT_TX: begin
          if (tx_valid_i) begin
            txByte_q  <= tx_data_i;
            state_q   <= S_WR_TX;
            txReady_q <= 1'b0;
          end
        end
        S_WR_TX: begin
          if (wbDone) state_q <= S_POLL;
        end
        S_POLL: begin
          if (wbDone && wbRdata[SR_TXE]) state_q <= S_RD_RX;
        end
        S_RD_RX: begin
          if (wbDone) begin
            rxByte_q  <= wbRdata[7:0];
            state_q   <= S_PUSH_RX;
            rxValid_q <= 1'b1;
          end
        end
        S_PUSH_RX: begin
          if (rx_ready_i) begin
            remaining_q <= remaining_q - 9'd1;
            rxValid_q   <= 1'b0;
            if (remaining_q == 9'd1) begin
              state_q   <= S_CDESEL;
            end else begin
              state_q   <= S_WAIT_TX;
              txReady_q <= 1'b1;
            end
          end
        end
        S_CDESEL: begin
          if (wbDone) begin
            state_q    <= S_IDLE;
            busy_q     <= 1'b0;
            cmdReady_q <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  ecap5_dwbspi_seq_wbm u_wbm (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .req_i      (wbReq),
    .we_i       (wbWe),
    .addr_i     (wbAddr),
    .wdata_i    (wbWdata),
    .done_o     (wbDone),
    .busy_o     (wbBusy),
    .rdata_o    (wbRdata),
    .wb_adr_o   (wb_adr_o),
    .wb_dat_o   (wb_dat_o),
    .wb_dat_i   (wb_dat_i),
    .wb_we_o    (wb_we_o),
    .wb_sel_o   (wb_sel_o),
    .wb_stb_o   (wb_stb_o),
    .wb_ack_i   (wb_ack_i),
    .wb_cyc_o   (wb_cyc_o),
    .wb_stall_i (wb_stall_i)
  );

  assign unusedRdata = ^wbRdata[31:8];

  assign cmd_ready_o = cmdReady_q;
  assign tx_ready_o  = txReady_q;
  assign rx_valid_o  = rxValid_q;
  assign rx_data_o   = rxByte_q;
  assign busy_o      = busy_q;
  assign done_o      = (state_q == S_CDESEL) && wbDone;

endmodule

// File: tb/tb_ecap5_dwbspi_seq.sv
// Randomized bench for ecap5_dwbspi_seq: a behavioural SPI register block
// (MISO = ~MOSI) answers on Wishbone and every transfer's bus trace is audited.
module tb_ecap5_dwbspi_seq;

  localparam logic [31:0] BASE   = 32'h0001_0100;
  localparam logic [31:0] A_SR   = BASE;
  localparam logic [31:0] A_CR   = BASE + 32'd4;
  localparam logic [31:0] A_RXDR = BASE + 32'd8;
  localparam logic [31:0] A_TXDR = BASE + 32'd12;
  localparam logic [31:0] CR_ON  = 32'h0004_0001;
  localparam logic [31:0] CR_OFF = 32'h0004_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [7:0]  cmd_len = 8'd0;
  logic        tx_valid = 1'b0;
  logic        tx_ready;
  logic [7:0]  tx_data = 8'd0;
  logic        rx_valid;
  logic        rx_ready = 1'b0;
  logic [7:0]  rx_data;
  logic        busy;
  logic        done;
  logic [31:0] wb_adr;
  logic [31:0] wb_dat_out;
  logic [31:0] wb_dat_in = 32'd0;
  logic        wb_we;
  logic [3:0]  wb_sel;
  logic        wb_stb;
  logic        wb_ack = 1'b0;
  logic        wb_cyc;
  logic        wb_stall = 1'b0;

  always #5 clk = ~clk;

  ecap5_dwbspi_seq #(.SPI_BASE(BASE), .PRESCALER(16'd4)) dut (
    .clk_i(clk), .rst_i(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_len_i(cmd_len),
    .tx_valid_i(tx_valid), .tx_ready_o(tx_ready), .tx_data_i(tx_data),
    .rx_valid_o(rx_valid), .rx_ready_i(rx_ready), .rx_data_o(rx_data),
    .busy_o(busy), .done_o(done),
    .wb_adr_o(wb_adr), .wb_dat_o(wb_dat_out), .wb_dat_i(wb_dat_in),
    .wb_we_o(wb_we), .wb_sel_o(wb_sel), .wb_stb_o(wb_stb),
    .wb_ack_i(wb_ack), .wb_cyc_o(wb_cyc), .wb_stall_i(wb_stall)
  );

  int checks = 0;
  int failures = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Completed bus accesses as seen by the slave model.
  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] wdat;
    logic [31:0] rdat;
    int          stbCyc;
    int          waitCyc;
    int          stallPlan;
    int          ackPlan;
    logic        rxValidAtStart;
  } access_t;

  access_t     accLog[$];
  logic [7:0]  txQ[$];
  logic [7:0]  txSent[$];
  logic [7:0]  expRx[$];
  logic [7:0]  rxGot[$];

  // Slave model state
  bit          active = 0;
  logic        curWe = 1'b0;
  logic [31:0] curAdr = 32'd0;
  logic [31:0] curDat = 32'd0;
  logic        curRxValid = 1'b0;
  int          stallCnt, ackCnt, stallPlan, ackPlan, stbCyc, waitCyc;
  int          pollsLeft = 0;
  logic [7:0]  rxReg = 8'd0;
  int          forceStall = -1;
  int          forceAck = -1;
  int          forcePolls = -1;

  // Handshake bookkeeping
  int          rxConsumed = 0;
  int          txAccepted = 0;
  int          doneCount = 0;
  int          exclViol = 0;
  int          selViol = 0;
  int          stabViol = 0;
  bit          rxHeldPrev = 0;
  logic [7:0]  rxPrevData = 8'd0;
  int          rxHoldIdx = -1;
  int          rxHoldLeft = 0;
  int          rxValidCycles = 0;

  task automatic finishAccess();
    logic [31:0] rdat;
    logic [31:0] junk;
    junk = $urandom;
    rdat = 32'd0;
    if (curWe) begin
      if (curAdr == A_TXDR) begin
        rxReg     = ~curDat[7:0];
        pollsLeft = (forcePolls >= 0) ? forcePolls : int'($urandom_range(0, 3));
        forcePolls = -1;
      end
    end else if (curAdr == A_SR) begin
      if (pollsLeft > 0) begin
        rdat = junk & 32'hFFFF_FFFE;
        pollsLeft--;
      end else begin
        rdat = junk | 32'h1;
      end
    end else if (curAdr == A_RXDR) begin
      rdat = (junk & 32'hFFFF_FF00) | {24'd0, rxReg};
    end
    wb_dat_in = rdat;
    accLog.push_back('{curWe, curAdr, curDat, rdat, stbCyc, waitCyc, stallPlan, ackPlan, curRxValid});
  endtask

  // Slave reacts just after each rising edge so its answer is stable for the next one.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      wb_ack    = 1'b0;
      wb_stall  = 1'b0;
      wb_dat_in = $urandom;
      if (rst || !wb_cyc) begin
        active = 0;
      end else begin
        if (wb_stb && !active) begin
          active     = 1;
          curWe      = wb_we;
          curAdr     = wb_adr;
          curDat     = wb_dat_out;
          curRxValid = rx_valid;
          stbCyc     = 0;
          waitCyc    = 0;
          stallPlan  = (forceStall >= 0) ? forceStall :
                       (($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0);
          ackPlan    = (forceAck >= 0) ? forceAck : int'($urandom_range(0, 2));
          forceStall = -1;
          forceAck   = -1;
          stallCnt   = stallPlan;
          ackCnt     = ackPlan;
        end
        if (wb_stb) begin
          stbCyc++;
          if (stallCnt > 0) begin
            wb_stall = 1'b1;
            stallCnt--;
          end else if (ackCnt == 0) begin
            wb_ack = 1'b1;
            finishAccess();
          end
        end else if (active) begin
          waitCyc++;
          ackCnt--;
          if (ackCnt <= 0) begin
            wb_ack = 1'b1;
            finishAccess();
          end
        end
      end
    end
  end

  // TX producer and RX consumer drive just after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (txQ.size() > 0 && $urandom_range(0, 2) != 0) begin
        tx_valid = 1'b1;
        tx_data  = txQ[0];
      end else begin
        tx_valid = 1'b0;
        tx_data  = 8'($urandom);
      end
      if (rx_valid && rxConsumed == rxHoldIdx && rxHoldLeft > 0) begin
        rx_ready = 1'b0;
        rxHoldLeft--;
      end else begin
        rx_ready = ($urandom_range(0, 3) != 0);
      end
    end
  end

  // Observe handshakes and invariants on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (tx_ready && rx_valid) exclViol++;
        if (wb_sel !== 4'hF) selViol++;
        if (rxHeldPrev && (!rx_valid || rx_data !== rxPrevData)) stabViol++;
        if (rx_valid) rxValidCycles++;
        if (done) begin
          doneCount++;
          checkOutput("doneOnDeselectAck",
                      {31'd0, wb_ack && wb_cyc && curWe && curAdr == A_CR && curDat == CR_OFF}, 32'd1);
        end
        if (rx_valid && rx_ready) begin
          if (rxConsumed == rxHoldIdx)
            checkOutput("rxHoldRespected", {31'd0, rxValidCycles >= 11}, 32'd1);
          if (expRx.size() == 0) begin
            checkOutput("rxUnexpected", {24'd0, rx_data}, 32'hFFFF_FFFF);
          end else begin
            checkOutput("rxData", {24'd0, rx_data}, {24'd0, expRx.pop_front()});
          end
          rxGot.push_back(rx_data);
          rxConsumed++;
          rxValidCycles = 0;
        end
        if (tx_valid && tx_ready) begin
          checkOutput("txAfterRxConsumed", 32'(txAccepted), 32'(rxConsumed));
          txAccepted++;
          if (txQ.size() > 0) void'(txQ.pop_front());
        end
        rxHeldPrev = rx_valid && !rx_ready;
        rxPrevData = rx_data;
      end
    end
  end

  task automatic checkAccess(input int k, input logic we, input logic [31:0] adr,
                             input logic [31:0] wdat, input string tag);
    if (k >= accLog.size()) begin
      checkOutput({tag, "Present"}, 32'(accLog.size()), 32'(k + 1));
      return;
    end
    checkOutput({tag, "We"}, {31'd0, accLog[k].we}, {31'd0, we});
    checkOutput({tag, "Adr"}, accLog[k].adr, adr);
    checkOutput({tag, "Dat"}, accLog[k].wdat, wdat);
    checkOutput({tag, "StbHold"}, 32'(accLog[k].stbCyc), 32'(accLog[k].stallPlan + 1));
    checkOutput({tag, "AckWait"}, 32'(accLog[k].waitCyc), 32'(accLog[k].ackPlan));
  endtask

  // Expected trace: CR select, per byte TXDR / SR* / SR(TXE) / RXDR, CR deselect.
  task automatic walkLog(input int n);
    int k;
    int f0;
    k  = 0;
    f0 = failures;
    checkAccess(k, 1'b1, A_CR, CR_ON, "crSelect");
    k++;
    for (int i = 0; i < n; i++) begin
      checkAccess(k, 1'b1, A_TXDR, {24'd0, txSent[i]}, "txdrWrite");
      if (k < accLog.size())
        checkOutput("txdrWhileRxValid", {31'd0, accLog[k].rxValidAtStart}, 32'd0);
      k++;
      while (k < accLog.size() && !accLog[k].we && accLog[k].adr == A_SR && accLog[k].rdat[0] == 1'b0) k++;
      checkAccess(k, 1'b0, A_SR, 32'd0, "srPoll");
      if (k < accLog.size())
        checkOutput("srPollTxe", {31'd0, accLog[k].rdat[0]}, 32'd1);
      k++;
      checkAccess(k, 1'b0, A_RXDR, 32'd0, "rxdrRead");
      k++;
      if (failures != f0) break;
    end
    if (failures == f0) begin
      checkAccess(k, 1'b1, A_CR, CR_OFF, "crDeselect");
      k++;
      checkOutput("accessCount", 32'(accLog.size()), 32'(k));
    end
  endtask

  task automatic clearScoreboard();
    accLog.delete();
    txQ.delete();
    txSent.delete();
    expRx.delete();
    rxGot.delete();
    rxConsumed    = 0;
    txAccepted    = 0;
    exclViol      = 0;
    selViol       = 0;
    stabViol      = 0;
    rxHeldPrev    = 0;
    rxValidCycles = 0;
  endtask

  // One full transfer; fixedBase >= 0 gives bytes fixedBase, fixedBase+1, ...
  task automatic applyStimulus(input int len, input int fixedBase, input bit injectCmd);
    int n;
    int budget;
    int doneBase;
    logic [7:0] b;
    n = (len == 0) ? 256 : len;
    clearScoreboard();
    for (int i = 0; i < n; i++) begin
      b = (fixedBase >= 0) ? 8'(fixedBase + i) : 8'($urandom);
      txQ.push_back(b);
      txSent.push_back(b);
      expRx.push_back(~b);
    end
    doneBase = doneCount;
    budget = 0;
    while (cmd_ready !== 1'b1 && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    checkOutput("cmdReadyIdle", {31'd0, cmd_ready}, 32'd1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b1;
    cmd_len   = 8'(len);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_len   = 8'($urandom);
    @(negedge clk);
    checkOutput("busyAfterCmd", {30'd0, busy, cmd_ready}, 32'b10);
    if (injectCmd) begin
      repeat (3) @(posedge clk);
      #1;
      cmd_valid = 1'b1;
      cmd_len   = 8'(len + 5);
      repeat (3) @(posedge clk);
      #1;
      cmd_valid = 1'b0;
    end
    budget = 0;
    while (doneCount == doneBase && budget < 30000) begin
      @(negedge clk);
      budget++;
    end
    repeat (6) @(negedge clk);
    checkOutput("donePulses", 32'(doneCount - doneBase), 32'd1);
    checkOutput("rxCount", 32'(rxConsumed), 32'(n));
    checkOutput("txCount", 32'(txAccepted), 32'(n));
    checkOutput("idleAfterDone", {30'd0, busy, cmd_ready}, 32'b01);
    checkOutput("txRxExclusive", 32'(exclViol), 32'd0);
    checkOutput("wbSelConstant", 32'(selViol), 32'd0);
    checkOutput("rxDataStable", 32'(stabViol), 32'd0);
    walkLog(n);
  endtask

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bit found;
    int budget;
    $display("[TB] start");
    repeat (3) @(negedge clk);
    checkOutput("rstWbCycStbWe", {29'd0, wb_cyc, wb_stb, wb_we}, 32'd0);
    checkOutput("rstWbAdr", wb_adr, 32'd0);
    checkOutput("rstWbDat", wb_dat_out, 32'd0);
    checkOutput("rstWbSel", {28'd0, wb_sel}, 32'hF);
    checkOutput("rstHandshakes", {27'd0, cmd_ready, tx_ready, rx_valid, busy, done}, 32'd0);
    checkOutput("rstRxData", {24'd0, rx_data}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("cmdReadyAfterRst", {31'd0, cmd_ready}, 32'd1);

    // single byte with known value
    applyStimulus(1, 8'hA5, 1'b0);
    checkOutput("t1RxByte", (rxGot.size() > 0) ? {24'd0, rxGot[0]} : 32'hFFFF_FFFF, 32'h5A);

    // three bytes, consumer stalls on the second RX byte
    rxHoldIdx  = 1;
    rxHoldLeft = 10;
    applyStimulus(3, 1, 1'b0);
    rxHoldIdx  = -1;
    checkOutput("t2RxOrder", (rxGot.size() == 3) ? {8'd0, rxGot[0], rxGot[1], rxGot[2]} : 32'hFFFF_FFFF,
                32'h00FE_FDFC);

    // length 0 means 256 bytes
    applyStimulus(0, -1, 1'b0);

    // stalled and late-acked chip select
    forceStall = 3;
    forceAck   = 2;
    applyStimulus(1, -1, 1'b0);
    if (accLog.size() > 0) begin
      checkOutput("cselStbCycles", 32'(accLog[0].stbCyc), 32'd4);
      checkOutput("cselAckWait", 32'(accLog[0].waitCyc), 32'd2);
    end else begin
      checkOutput("cselLogged", 32'(accLog.size()), 32'd1);
    end

    // reset while a status poll is on the bus
    clearScoreboard();
    txQ.push_back(8'h3C);
    forcePolls = 6;
    @(posedge clk);
    #1;
    cmd_valid = 1'b1;
    cmd_len   = 8'd1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    found  = 0;
    budget = 0;
    while (!found && budget < 300) begin
      @(posedge clk);
      #1;
      found = wb_cyc && !wb_we && wb_adr == A_SR;
      budget++;
    end
    checkOutput("pollReached", {31'd0, found}, 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("asyncRstBus", {30'd0, wb_cyc, wb_stb}, 32'd0);
    checkOutput("asyncRstBusy", {31'd0, busy}, 32'd0);
    checkOutput("asyncRstReady", {29'd0, cmd_ready, tx_ready, rx_valid}, 32'd0);
    repeat (3) @(negedge clk);
    clearScoreboard();
    forcePolls = -1;
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("readyAfterMidRst", {31'd0, cmd_ready}, 32'd1);
    applyStimulus(1, -1, 1'b0);

    // command pulsed while busy is ignored
    applyStimulus(4, -1, 1'b1);

    // random lengths
    for (int t = 0; t < 5; t++) begin
      applyStimulus(int'($urandom_range(1, 12)), -1, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
